// File: rtl/multiport_register_file_pkg.sv
// Shared configuration and types for the multiport register file.
// Provides data/ID widths, register count, writeback port count,
// the INIT/RUN state enum and the packed writeback port payload.
package multiport_register_file_pkg;

  localparam int unsigned XLEN                    = 32;
  localparam int unsigned NUM_REGS                = 32;
  localparam int unsigned INSTRUCTION_QUEUE_DEPTH = 8;
  localparam int unsigned ID_W                    = $clog2(INSTRUCTION_QUEUE_DEPTH);
  localparam int unsigned NUM_WB                  = 2;
  localparam int unsigned AW                      = $clog2(NUM_REGS);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_init_state_t;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd_addr;
    logic [ID_W-1:0] id;
    logic [XLEN-1:0] data;
  } wb_port_t;

endpackage

// File: rtl/multiport_register_file_if.sv
// Issue/read/writeback bundle of the multiport register file.
// master: decode/issue + writeback side (drives addresses, issue, flush, wb_*).
// slave:  register file (drives ready, rs1/rs2 data and conflict flags).
interface multiport_register_file_if;
  import multiport_register_file_pkg::*;

  logic                           ready;
  logic                           flush;
  logic [AW-1:0]                  rs1_addr;
  logic [AW-1:0]                  rs2_addr;
  logic [XLEN-1:0]                rs1;
  logic [XLEN-1:0]                rs2;
  logic                           rs1_conflict;
  logic                           rs2_conflict;
  logic                           issue;
  logic [AW-1:0]                  future_rd_addr;
  logic [ID_W-1:0]                id;
  logic [NUM_WB-1:0]              wb_valid;
  logic [NUM_WB-1:0][AW-1:0]      wb_rd_addr;
  logic [NUM_WB-1:0][ID_W-1:0]    wb_id;
  logic [NUM_WB-1:0][XLEN-1:0]    wb_data;

  modport master (
    input  ready, rs1, rs2, rs1_conflict, rs2_conflict,
    output flush, rs1_addr, rs2_addr, issue, future_rd_addr, id,
           wb_valid, wb_rd_addr, wb_id, wb_data
  );

  modport slave (
    output ready, rs1, rs2, rs1_conflict, rs2_conflict,
    input  flush, rs1_addr, rs2_addr, issue, future_rd_addr, id,
           wb_valid, wb_rd_addr, wb_id, wb_data
  );

endinterface

// File: rtl/multiport_register_file_rf_scoreboard.sv
// Reservation scoreboard: tracks which registers have an outstanding writer
// and that writer's ID, and qualifies each writeback port for commit.
// Ports: clk, rst (async active-low), run (normal operation), init_en/init_idx
// (clear one entry per cycle during init), flush, issue/future_rd_addr/id,
// wb (per-port payloads), commit_c (per-port commit, combinational),
// inuse (per-register reservation bits).
module rf_scoreboard
  import multiport_register_file_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   init_en,
  input  logic [AW-1:0]          init_idx,
  input  logic                   flush,
  input  logic                   issue,
  input  logic [AW-1:0]          future_rd_addr,
  input  logic [ID_W-1:0]        id,
  input  wb_port_t [NUM_WB-1:0]  wb,
  output logic [NUM_WB-1:0]      commit_c,
  output logic [NUM_REGS-1:0]    inuse
);

  logic [ID_W-1:0]   in_use_by [NUM_REGS];
  logic [NUM_WB-1:0] qual;

  // Commit qualification; a lower-index port claiming the same register masks higher ones.
  always_comb begin
    qual = '0;
    for (int p = 0; p < int'(NUM_WB); p++) begin
      qual[p] = run && wb[p].valid && (wb[p].rd_addr != '0) &&
                inuse[wb[p].rd_addr] && (in_use_by[wb[p].rd_addr] == wb[p].id);
      for (int q = 0; q < p; q++) begin
        if (qual[q] && (wb[q].rd_addr == wb[p].rd_addr)) qual[p] = 1'b0;
      end
    end
    commit_c = qual;
  end

  // Reservation state; later assignments win: commit clear < issue set < flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inuse <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) in_use_by[i] <= '0;
    end else if (init_en) begin
      inuse[init_idx]     <= 1'b0;
      in_use_by[init_idx] <= '0;
    end else if (run) begin
      for (int p = 0; p < int'(NUM_WB); p++) begin
        if (qual[p]) inuse[wb[p].rd_addr] <= 1'b0;
      end
      if (flush) begin
        inuse <= '0;
      end else if (issue && (future_rd_addr != '0)) begin
        inuse[future_rd_addr]     <= 1'b1;
        in_use_by[future_rd_addr] <= id;
      end
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Integer register file with ID-tracked scoreboard: one issue slot (two
// source reads + one destination reservation), NUM_WB writeback ports,
// flush of all reservations, and a post-reset sweep zeroing the storage.
// Ports: clk, rst (async active-low), bus (multiport_register_file_if.slave).
// Optional macro REGFILE_FORWARDING_EN: forward committing writebacks to
// same-cycle source reads (lowest-index port first).
module multiport_register_file
  import multiport_register_file_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  multiport_register_file_if.slave bus
);

  rf_init_state_t          state;
  rf_init_state_t          next_state;
  logic [AW-1:0]           counter;
  logic                    ready;
  logic                    init_en;
  wb_port_t [NUM_WB-1:0]   wb;
  logic [NUM_WB-1:0]       commit_c;
  logic [NUM_REGS-1:0]     inuse;
  logic [XLEN-1:0]         regs [NUM_REGS];
  logic [AW-1:0]           rs_addr [2];
  logic [XLEN-1:0]         rs_data [2];
  logic [1:0]              rs_conf;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= next_state;
  end

  // Next state: leave INIT once the last register has been cleared
  always_comb begin
    next_state = state;
    if ((state == INIT) && (counter == AW'(NUM_REGS - 1))) next_state = RUN;
  end

  // State decode
  always_comb begin
    ready   = 1'b0;
    init_en = 1'b0;
    case (state)
      INIT:    init_en = 1'b1;
      RUN:     ready   = 1'b1;
      default: ;
    endcase
  end

  // Init sweep index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         counter <= '0;
    else if (init_en) counter <= counter + AW'(1);
  end

  // Pack writeback ports
  always_comb begin
    wb = '0;
    for (int p = 0; p < int'(NUM_WB); p++) begin
      wb[p].valid   = bus.wb_valid[p];
      wb[p].rd_addr = bus.wb_rd_addr[p];
      wb[p].id      = bus.wb_id[p];
      wb[p].data    = bus.wb_data[p];
    end
  end

  rf_scoreboard u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .run            (ready),
    .init_en        (init_en),
    .init_idx       (counter),
    .flush          (bus.flush),
    .issue          (bus.issue),
    .future_rd_addr (bus.future_rd_addr),
    .id             (bus.id),
    .wb             (wb),
    .commit_c       (commit_c),
    .inuse          (inuse)
  );

  // Storage: zeroed during init, then written by qualified commits
  always_ff @(posedge clk) begin
    if (init_en) begin
      regs[counter] <= '0;
    end else begin
      for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
        if (commit_c[p]) regs[wb[p].rd_addr] <= wb[p].data;
      end
    end
  end

  assign rs_addr[0] = bus.rs1_addr;
  assign rs_addr[1] = bus.rs2_addr;

  // Source reads; outputs are pinned to 0 / conflict during init
  always_comb begin
    rs_data[0] = '0;
    rs_data[1] = '0;
    rs_conf    = '1;
    for (int r = 0; r < 2; r++) begin
      if (ready) begin
        if (rs_addr[r] == '0) begin
          rs_data[r] = '0;
          rs_conf[r] = 1'b0;
        end else begin
          rs_data[r] = regs[rs_addr[r]];
          rs_conf[r] = inuse[rs_addr[r]];
`ifdef REGFILE_FORWARDING_EN
          // Descending scan so the lowest-index matching port ends up forwarded
          for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
            if (commit_c[p] && (wb[p].rd_addr == rs_addr[r])) begin
              rs_data[r] = wb[p].data;
              rs_conf[r] = 1'b0;
            end
          end
`endif
        end
      end
    end
  end

  assign bus.ready        = ready;
  assign bus.rs1          = rs_data[0];
  assign bus.rs2          = rs_data[1];
  assign bus.rs1_conflict = rs_conf[0];
  assign bus.rs2_conflict = rs_conf[1];

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed self-checking bench for multiport_register_file.
module tb_multiport_register_file;
  import multiport_register_file_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  multiport_register_file_if bus ();

  multiport_register_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush          = 1'b0;
    bus.issue          = 1'b0;
    bus.future_rd_addr = '0;
    bus.id             = '0;
    bus.wb_valid       = '0;
    bus.wb_rd_addr     = '0;
    bus.wb_id          = '0;
    bus.wb_data        = '0;
  endtask

  task automatic do_issue(input logic [AW-1:0] rd, input logic [ID_W-1:0] iid);
    bus.issue          = 1'b1;
    bus.future_rd_addr = rd;
    bus.id             = iid;
  endtask

  task automatic do_wb(input int port, input logic [AW-1:0] rd,
                       input logic [ID_W-1:0] iid, input logic [XLEN-1:0] data);
    bus.wb_valid[port]   = 1'b1;
    bus.wb_rd_addr[port] = rd;
    bus.wb_id[port]      = iid;
    bus.wb_data[port]    = data;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.rs1_addr = 5'd5;
    bus.rs2_addr = 5'd0;
    clear_inputs();

    // During reset
    #3;
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_rs1_conflict", 32'(bus.rs1_conflict), 32'd1);
    check("rst_rs2_conflict", 32'(bus.rs2_conflict), 32'd1);
    check("rst_rs1", bus.rs1, 32'd0);

    // Release away from the edge; INIT lasts 32 cycles
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      check("init_ready", 32'(bus.ready), 32'd0);
      check("init_rs1_conflict", 32'(bus.rs1_conflict), 32'd1);
      step();
    end
    check("ready_rise", 32'(bus.ready), 32'd1);

    // Every register zero and free after init
    for (int a = 0; a < 32; a++) begin
      bus.rs1_addr = AW'(a);
      bus.rs2_addr = AW'(31 - a);
      #1;
      check("post_init_rs1", bus.rs1, 32'd0);
      check("post_init_rs1_conflict", 32'(bus.rs1_conflict), 32'd0);
      check("post_init_rs2_conflict", 32'(bus.rs2_conflict), 32'd0);
      step();
    end

    // Issue x5 id3, then commit from port 1
    do_issue(5'd5, 3'd3);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd5;
    #1;
    check("x5_reserved", 32'(bus.rs1_conflict), 32'd1);
    do_wb(1, 5'd5, 3'd3, 32'hDEADBEEF);
    #1;
`ifdef REGFILE_FORWARDING_EN
    check("x5_fwd_data", bus.rs1, 32'hDEADBEEF);
    check("x5_fwd_conflict", 32'(bus.rs1_conflict), 32'd0);
`else
    check("x5_nofwd_data", bus.rs1, 32'd0);
    check("x5_nofwd_conflict", 32'(bus.rs1_conflict), 32'd1);
`endif
    step();
    clear_inputs();
    #1;
    check("x5_data", bus.rs1, 32'hDEADBEEF);
    check("x5_conflict", 32'(bus.rs1_conflict), 32'd0);

    // Stale ID is dropped, latest writer commits
    do_issue(5'd7, 3'd1);
    step();
    do_issue(5'd7, 3'd2);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd7;
    do_wb(0, 5'd7, 3'd1, 32'h11);
    #1;
    check("x7_stale_conflict_now", 32'(bus.rs1_conflict), 32'd1);
    step();
    clear_inputs();
    #1;
    check("x7_stale_data", bus.rs1, 32'd0);
    check("x7_stale_conflict", 32'(bus.rs1_conflict), 32'd1);
    do_wb(1, 5'd7, 3'd2, 32'h22);
    step();
    clear_inputs();
    #1;
    check("x7_data", bus.rs1, 32'h22);
    check("x7_conflict", 32'(bus.rs1_conflict), 32'd0);

    // Flush drops reservation; later writeback is ignored
    do_issue(5'd9, 3'd4);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd9;
    #1;
    check("x9_reserved", 32'(bus.rs1_conflict), 32'd1);
    bus.flush = 1'b1;
    step();
    clear_inputs();
    #1;
    check("x9_flushed_conflict", 32'(bus.rs1_conflict), 32'd0);
    do_wb(0, 5'd9, 3'd4, 32'h99);
    step();
    clear_inputs();
    #1;
    check("x9_data_kept", bus.rs1, 32'd0);
    check("x9_conflict", 32'(bus.rs1_conflict), 32'd0);

    // Flush beats same-cycle issue
    bus.flush = 1'b1;
    do_issue(5'd10, 3'd2);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd10;
    #1;
    check("x10_issue_dropped", 32'(bus.rs1_conflict), 32'd0);

    // Commit qualified in flush cycle still writes
    do_issue(5'd11, 3'd3);
    step();
    clear_inputs();
    bus.flush = 1'b1;
    do_wb(0, 5'd11, 3'd3, 32'h77);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd11;
    #1;
    check("x11_flush_commit_data", bus.rs1, 32'h77);
    check("x11_flush_commit_conflict", 32'(bus.rs1_conflict), 32'd0);

    // Same-cycle issue and commit: data written, new owner kept
    do_issue(5'd3, 3'd5);
    step();
    clear_inputs();
    do_issue(5'd3, 3'd6);
    do_wb(0, 5'd3, 3'd5, 32'h33);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd3;
    #1;
    check("x3_data", bus.rs1, 32'h33);
    check("x3_conflict", 32'(bus.rs1_conflict), 32'd1);
    do_wb(0, 5'd3, 3'd5, 32'h44);
    step();
    clear_inputs();
    #1;
    check("x3_old_id_dropped", bus.rs1, 32'h33);
    do_wb(1, 5'd3, 3'd6, 32'h55);
    step();
    clear_inputs();
    #1;
    check("x3_new_id_data", bus.rs1, 32'h55);
    check("x3_new_id_conflict", 32'(bus.rs1_conflict), 32'd0);

    // Both ports hit the same register: port 0 wins
    do_issue(5'd12, 3'd1);
    step();
    clear_inputs();
    bus.rs2_addr = 5'd12;
    do_wb(0, 5'd12, 3'd1, 32'hA0);
    do_wb(1, 5'd12, 3'd1, 32'hB0);
    #1;
`ifdef REGFILE_FORWARDING_EN
    check("x12_fwd_data", bus.rs2, 32'hA0);
    check("x12_fwd_conflict", 32'(bus.rs2_conflict), 32'd0);
`else
    check("x12_nofwd_conflict", 32'(bus.rs2_conflict), 32'd1);
`endif
    step();
    clear_inputs();
    #1;
    check("x12_data", bus.rs2, 32'hA0);
    check("x12_conflict", 32'(bus.rs2_conflict), 32'd0);

    // Register 0 is immune to writes and reservations
    do_issue(5'd0, 3'd1);
    do_wb(0, 5'd0, 3'd0, 32'hFF);
    do_wb(1, 5'd0, 3'd0, 32'hFF);
    step();
    clear_inputs();
    bus.rs1_addr = 5'd0;
    bus.rs2_addr = 5'd0;
    #1;
    check("x0_rs1", bus.rs1, 32'd0);
    check("x0_rs2", bus.rs2, 32'd0);
    check("x0_rs1_conflict", 32'(bus.rs1_conflict), 32'd0);
    check("x0_rs2_conflict", 32'(bus.rs2_conflict), 32'd0);

    // Reset mid-operation returns to INIT at once
    bus.rs1_addr = 5'd5;
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd0);
    check("midrst_rs1", bus.rs1, 32'd0);
    check("midrst_rs1_conflict", 32'(bus.rs1_conflict), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Integer register file with an ID-tracked scoreboard, sitting between decode/issue and the out-of-order writeback network. It serves one issue slot (two source reads plus one destination reservation) and commits from NUM_WB independent writeback ports. Each writeback is accepted only if it is the latest outstanding writer of its register. A flush clears all reservations for exception recovery, and a post-reset init sequence zeroes the storage.

## Interface
- XLEN, 32: register data width.
- NUM_REGS, 32: architectural register count; register 0 is hardwired zero. Power of two, at least 2.
- ID_W, 3: instruction ID width. Equals $clog2(INSTRUCTION_QUEUE_DEPTH).
- NUM_WB, 2: number of writeback ports, at least 1.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- ready  out  1  high once storage init completes; issue is illegal while low.
- flush  in  1  clears every scoreboard reservation.
- rs1_addr, rs2_addr  in  $clog2(NUM_REGS) each  source register addresses.
- rs1, rs2  out  XLEN each  source operand data.
- rs1_conflict, rs2_conflict  out  1 each  source has an uncommitted writer.
- issue  in  1  reserves future_rd_addr for id.
- future_rd_addr  in  $clog2(NUM_REGS)  destination being reserved.
- id  in  ID_W  issuing instruction ID.
- wb_valid  in  NUM_WB  per-port write strobe.
- wb_rd_addr  in  NUM_WB×$clog2(NUM_REGS)  per-port destination.
- wb_id  in  NUM_WB×ID_W  per-port producer ID.
- wb_data  in  NUM_WB×XLEN  per-port result.

## Operation
- States INIT and RUN. Reset enters INIT with counter=0. INIT writes zero to register[counter], clears inuse[counter] and in_use_by[counter], then increments. After counter reaches NUM_REGS-1 the FSM moves to RUN. Reset asserted mid-operation returns to INIT unconditionally.
- Outputs in INIT and at reset: ready=0, rs1=rs2=0, rs1_conflict=rs2_conflict=1. issue, flush and wb_valid are ignored.
- Port p commits when wb_valid[p], wb_rd_addr[p]≠0, inuse[rd]=1 and in_use_by[rd]==wb_id[p]. A commit writes the data and clears inuse[rd].
- Writebacks to an unreserved register or carrying a stale ID are dropped silently.
- Issue with future_rd_addr≠0 sets inuse and in_use_by to id. Issue to register 0 has no effect.
- Issue and commit to the same register in one cycle: data is written, and issue wins the scoreboard (inuse stays 1, new ID).
- Two ports matching the same register in one cycle is illegal. If it occurs, the lowest-index port wins.
- flush clears all inuse bits in one cycle and has priority over any same-cycle issue, which is dropped. Commits qualified in the flush cycle still write data.
- Reads: register 0 reads 0 with conflict 0. Conflict = inuse[rs] & ~forward.

## Timing
- Reads are combinational from addresses and current state. Commit is visible through storage on the next cycle.
- INIT lasts exactly NUM_REGS cycles after rst deasserts; ready rises on the cycle after that.
- Scoreboard update after issue is visible to reads on the next cycle.
- Flush effect is visible on the next cycle.

## Configuration
- REGFILE_FORWARDING_EN defined: a committing writeback is forwarded combinationally to a matching rs read in the same cycle, with conflict low. If several ports match, the lowest-index port is forwarded.
- Not defined: no bypass. Reads come only from storage, conflict = inuse[rs], and the operand becomes available one cycle after commit.

## Structure
- XLEN and INSTRUCTION_QUEUE_DEPTH come from riscv_config.
- The rf_init_state_t enum (INIT, RUN) and the packed wb_port_t struct {valid, rd_addr, id, data} go in riscv_types.
- Scoreboard (inuse, in_use_by, flush, commit qualification per port) lives in sub-module rf_scoreboard. It outputs the per-port commit vector to the top level, which owns storage, INIT FSM and forwarding.

## Test plan
- Reset, then hold rst high: ready low for 32 cycles, rs1_conflict=1 throughout. Afterwards every register reads 0 with no conflict.
- Issue x5 with id 3; next cycle rs1_addr=5 → conflict 1. Port 1 writes x5, id 3, 0xDEADBEEF: forwarding build gives same-cycle rs1=0xDEADBEEF, conflict 0; both builds read it next cycle.
- Issue x7 id 1, then x7 id 2. Port 0 writes x7 id 1 with 0x11 → dropped, conflict stays 1. Port 1 writes id 2 with 0x22 → x7=0x22.
- Issue x9 id 4, flush, then write x9 id 4 → dropped, conflict 0, old value retained.
- Same cycle: issue x3 id 6 while port 0 commits x3 under prior id 5 → data written, inuse[3]=1 owned by 6.
- Write x0 with 0xFF on both ports → x0 still reads 0, no conflict.
